rst_seq_ctrl: RTL



---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_sync_2ff.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencing controller.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough for both the settle delay and the init-done timeout.
    function automatic int cnt_width(input int dly, input int tmo);
        return $clog2(max_int(dly, tmo)) + 1;
    endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second clock edge after arst_in_n goes high.
module rst_sync_2ff (
    input  logic clk,
    input  logic arst_in_n,
    output logic rst_s_n
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge arst_in_n) begin
        if (!arst_in_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_s_n = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_DOM domain resets in index order, each after a
// settle delay and the previous domain's init-done. Optional RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM = 4,
    parameter int DLY_CYC = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       arst_in_n,
    input  logic                       sw_rst_req,
    input  logic [NUM_DOM-1:0]         dom_done,
    output logic [NUM_DOM-1:0]         dom_rst_n,
    output logic                       seq_busy,
    output logic                       seq_done,
    output logic [$clog2(NUM_DOM)-1:0] cur_dom,
    output logic [NUM_DOM-1:0]         tmo_err
);

    localparam int CW = $clog2(NUM_DOM);
    localparam int NW = cnt_width(DLY_CYC, TMO_CYC);
    localparam logic [CW-1:0] LAST_DOM = CW'(NUM_DOM - 1);
    localparam logic [NW-1:0] DLY_LAST = NW'(DLY_CYC - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [NW-1:0] TMO_LAST = NW'(TMO_CYC - 1);
`endif

    logic rst_s_n;

    rst_sync_2ff u_sync (
        .clk       (clk),
        .arst_in_n (arst_in_n),
        .rst_s_n   (rst_s_n)
    );

    seq_state_t        state_q, state_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cur_q, cur_d;
    logic [NUM_DOM-1:0] rel_q, rel_d;
    logic [NUM_DOM-1:0] tmo_q, tmo_d;
    logic              adv;

    always_ff @(posedge clk or negedge arst_in_n) begin
        if (!arst_in_n) begin
            state_q <= RST;
            cnt_q   <= '0;
            cur_q   <= '0;
            rel_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            rel_q   <= rel_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        rel_d   = rel_q;
        tmo_d   = tmo_q;
        adv     = 1'b0;

        unique case (state_q)
            RST: begin
                if (rst_s_n) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == DLY_LAST) begin
                    rel_d[cur_q] = 1'b1;
                    state_d      = WAIT;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            WAIT: begin
                adv = dom_done[cur_q];
`ifdef RST_SEQ_TIMEOUT_EN
                if (!adv) begin
                    if (cnt_q == TMO_LAST) begin
                        tmo_d[cur_q] = 1'b1;
                        adv          = 1'b1;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
`endif
                if (adv) begin
                    cnt_d = '0;
                    if (cur_q == LAST_DOM) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_q + CW'(1);
                        state_d = HOLD;
                    end
                end
            end
            DONE: begin
            end
        endcase

        // Soft reset overrides any advance decided above; ignored while in RST.
        if (sw_rst_req && (state_q != RST)) begin
            state_d = HOLD;
            cnt_d   = '0;
            cur_d   = '0;
            rel_d   = '0;
            tmo_d   = '0;
        end
    end

    assign dom_rst_n = rel_q;
    assign cur_dom   = cur_q;
    assign seq_busy  = (state_q == HOLD) || (state_q == WAIT);
    assign seq_done  = (state_q == DONE);
`ifdef RST_SEQ_TIMEOUT_EN
    assign tmo_err   = tmo_q;
`else
    assign tmo_err   = '0;
`endif

endmodule
